branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 74 +++++++
 tb/tb_branch_target_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// taken-branch allocation from EX, and a saturating count of redirect cycles.
module branch_target_buffer #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Fetch_PC,
  input  logic        Branch_likely,
  output logic        Hit,
  output logic [31:0] Pred_Target,
  output logic        Redirect,
  input  logic        Update,
  input  logic [31:0] Update_PC,
  input  logic [31:0] Update_Target,
  input  logic        Branch_Actual,
  input  logic        Invalidate_All,
  output logic [15:0] Redirect_Count
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [29:0]        target_mem [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] update_idx;
  logic [TAG_W-1:0] update_tag;
  logic             write_en;

  // Word-aligned PCs only; the byte-offset bits carry no information here.
  logic unused_low_bits;
  assign unused_low_bits = ^{Fetch_PC[1:0], Update_PC[1:0], Update_Target[1:0]};

  assign fetch_idx  = Fetch_PC[IDX_W+1:2];
  assign fetch_tag  = Fetch_PC[31:IDX_W+2];
  assign update_idx = Update_PC[IDX_W+1:2];
  assign update_tag = Update_PC[31:IDX_W+2];

  // Reset and a flush both suppress allocation in the same cycle.
  assign write_en = Update && Branch_Actual && !Invalidate_All && !reset;

  assign Hit         = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
  assign Pred_Target = Hit ? {target_mem[fetch_idx], 2'b00} : 32'h0;
  assign Redirect    = Hit && Branch_likely;

  always_ff @(posedge clk) begin
    if (reset || Invalidate_All) begin
      valid <= '0;
    end else if (write_en) begin
      valid[update_idx] <= 1'b1;
    end
  end

  // Payload storage is never cleared; the valid bits alone gate its use.
  always_ff @(posedge clk) begin
    if (write_en) begin
      tag_mem[update_idx]    <= update_tag;
      target_mem[update_idx] <= Update_Target[31:2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Redirect_Count <= 16'h0;
    end else if (Redirect && (Redirect_Count != 16'hFFFF)) begin
      Redirect_Count <= Redirect_Count + 16'h1;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: stimulus pushes expectations from
// a PC-level reference model, a negedge monitor pops and compares them.
module tb_branch_target_buffer;

  localparam int IDX_W   = 4;
  localparam int ENTRIES = 1 << IDX_W;

  logic        clk;
  logic        reset;
  logic [31:0] Fetch_PC;
  logic        Branch_likely;
  logic        Hit;
  logic [31:0] Pred_Target;
  logic        Redirect;
  logic        Update;
  logic [31:0] Update_PC;
  logic [31:0] Update_Target;
  logic        Branch_Actual;
  logic        Invalidate_All;
  logic [15:0] Redirect_Count;

  branch_target_buffer #(.IDX_W(IDX_W)) dut (
    .clk(clk),
    .reset(reset),
    .Fetch_PC(Fetch_PC),
    .Branch_likely(Branch_likely),
    .Hit(Hit),
    .Pred_Target(Pred_Target),
    .Redirect(Redirect),
    .Update(Update),
    .Update_PC(Update_PC),
    .Update_Target(Update_Target),
    .Branch_Actual(Branch_Actual),
    .Invalidate_All(Invalidate_All),
    .Redirect_Count(Redirect_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [31:0] target;
    logic        redirect;
    logic [31:0] count;
  } expect_t;

  expect_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: remembers the whole PC of the branch that owns each slot.
  bit          m_valid [ENTRIES];
  logic [31:0] m_pc    [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_count;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, records the expected outputs, then advances the model.
  task automatic applyStimulus(input bit rst, input logic [31:0] fpc, input bit bl,
                               input bit upd, input logic [31:0] upc,
                               input logic [31:0] utgt, input bit bact, input bit inv);
    expect_t e;
    int s;
    reset = rst; Fetch_PC = fpc; Branch_likely = bl; Update = upd;
    Update_PC = upc; Update_Target = utgt; Branch_Actual = bact; Invalidate_All = inv;

    s = slot_of(fpc);
    e.hit      = m_valid[s] && (tag_of(m_pc[s]) == tag_of(fpc));
    e.target   = e.hit ? (m_tgt[s] & 32'hFFFF_FFFC) : 32'h0;
    e.redirect = e.hit && bl;
    e.count    = 32'(m_count);
    exp_q.push_back(e);

    if (rst) begin
      model_clear();
      m_count = 0;
    end else begin
      if (e.redirect && m_count < 65535) m_count++;
      if (inv) begin
        model_clear();
      end else if (upd && bact) begin
        m_valid[slot_of(upc)] = 1'b1;
        m_pc[slot_of(upc)]    = upc;
        m_tgt[slot_of(upc)]   = utgt;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] fpc, input bit bl);
    applyStimulus(1'b0, fpc, bl, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic write_taken(input logic [31:0] upc, input logic [31:0] utgt);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, upc, utgt, 1'b1, 1'b0);
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("hit", {31'b0, Hit}, {31'b0, e.hit});
        checkOutput("pred_target", Pred_Target, e.target);
        checkOutput("redirect", {31'b0, Redirect}, {31'b0, e.redirect});
        checkOutput("redirect_count", {16'b0, Redirect_Count}, e.count);
      end
    end
  end

  initial begin : stimulus
    logic [31:0] pc;
    int drain;
    reset = 1'b1; Fetch_PC = 32'h0; Branch_likely = 1'b0; Update = 1'b0;
    Update_PC = 32'h0; Update_Target = 32'h0; Branch_Actual = 1'b0; Invalidate_All = 1'b0;
    model_clear();
    m_count = 0;
    @(posedge clk);
    #1;

    // Post-reset miss, first allocation, then hit with and without a taken prediction.
    lookup(32'h0040_0010, 1'b1);
    applyStimulus(1'b0, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0010, 32'h0040_0100, 1'b1, 1'b0);
    lookup(32'h0040_0010, 1'b1);
    lookup(32'h0040_0010, 1'b0);

    // Aliasing replacement, not-taken update, and flush beating a same-cycle write.
    write_taken(32'h0080_0010, 32'h0000_2000);
    lookup(32'h0040_0010, 1'b0);
    lookup(32'h0080_0010, 1'b0);
    applyStimulus(1'b0, 32'h0080_0010, 1'b0, 1'b1, 32'h0080_0010, 32'h0000_3000, 1'b0, 1'b0);
    lookup(32'h0080_0010, 1'b1);
    applyStimulus(1'b0, 32'h0080_0010, 1'b1, 1'b1, 32'h0080_0010, 32'h0000_4000, 1'b1, 1'b1);
    lookup(32'h0080_0010, 1'b1);

    // Target low bits dropped; same-index write and lookup sees old contents first.
    write_taken(32'h0000_0104, 32'h0000_1237);
    lookup(32'h0000_0106, 1'b1);
    applyStimulus(1'b0, 32'h0000_0104, 1'b1, 1'b1, 32'h0000_0104, 32'h0000_5000, 1'b1, 1'b0);
    lookup(32'h0000_0104, 1'b1);

    // Reset outranks a same-cycle taken update.
    applyStimulus(1'b1, 32'h0000_0104, 1'b1, 1'b1, 32'h0000_0204, 32'h0000_6000, 1'b1, 1'b0);
    lookup(32'h0000_0204, 1'b1);
    lookup(32'h0000_0104, 1'b1);

    // Randomized traffic over a few aliasing tags.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] fpc, upc;
      fpc = ($urandom_range(0, 2) << (IDX_W + 2)) | ($urandom_range(0, ENTRIES - 1) << 2)
            | $urandom_range(0, 3);
      upc = ($urandom_range(0, 2) << (IDX_W + 2)) | ($urandom_range(0, ENTRIES - 1) << 2)
            | $urandom_range(0, 3);
      applyStimulus(1'b0, fpc, 1'($urandom), 1'($urandom_range(0, 3) != 0), upc, $urandom,
                    1'($urandom), 1'($urandom_range(0, 40) == 0));
    end

    // Fill every slot, saturate the counter, then reset mid-run and sweep all indices.
    for (int i = 0; i < ENTRIES; i++) write_taken(32'h0040_0000 | 32'(i << 2), 32'h0010_0000 + 32'(i << 4));
    pc = 32'h0040_0010;
    for (int n = 0; n < 65600; n++) lookup(pc, 1'b1);
    applyStimulus(1'b1, pc, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < ENTRIES; i++) lookup(32'h0040_0000 | 32'(i << 2), 1'b1);

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
